// File: rtl/inst_queue_pkg.sv
// inst_queue_pkg: shared widths, queue-entry layout and helpers for the fetch-side instruction queue
package inst_queue_pkg;
    localparam int IQ_DEPTH    = 16;
    localparam int INST_NUM    = 4;
    localparam int SINGLE_WORD = 32;
    localparam int EXCCODE     = 5;
    localparam int IQ_ENTRY    = 104;
    typedef struct packed {
        logic [31:0]        pc;
        logic [31:0]        inst;
        logic               has_exc;
        logic [EXCCODE-1:0] exc_code;
        logic               is_refill;
        logic               pred_take;
        logic [31:0]        pred_dest;
    } iq_entry_t;
    function automatic logic [2:0] popcount4(input logic [INST_NUM-1:0] m);
        return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
    endfunction
endpackage

// File: rtl/inst_queue_if.sv
// inst_queue_if: fetch-packet, decode-dequeue and head-entry signals of the instruction queue
//   master: fetch/decode side (drives packet, flush, deqNum; sees allowin and head entries)
//   slave : the queue itself
interface inst_queue_if;
    import inst_queue_pkg::*;
    logic                              SCT_valid_i;
    logic [INST_NUM*SINGLE_WORD-1:0]   inst_rdata_i;
    logic [INST_NUM-1:0]               SCT_originEnable_i;
    logic [31:0]                       SCT_VAddr_i;
    logic                              SCT_hasException_i;
    logic [EXCCODE-1:0]                SCT_ExcCode_i;
    logic                              SCT_isRefill_i;
    logic [INST_NUM-1:0]               SCT_predTake_p_i;
    logic [INST_NUM*SINGLE_WORD-1:0]   SCT_predDest_p_i;
    logic                              flush_w_i;
    logic                              IQ_allowin_w_o;
    logic [1:0]                        ID_deqNum_i;
    logic [1:0]                        IQ_valid_o;
    logic [63:0]                       IQ_pc_o;
    logic [63:0]                       IQ_inst_o;
    logic [1:0]                        IQ_hasException_o;
    logic [2*EXCCODE-1:0]              IQ_ExcCode_o;
    logic [1:0]                        IQ_isRefill_o;
    logic [1:0]                        IQ_predTake_o;
    logic [63:0]                       IQ_predDest_o;
    modport master (
        output SCT_valid_i, inst_rdata_i, SCT_originEnable_i, SCT_VAddr_i, SCT_hasException_i,
               SCT_ExcCode_i, SCT_isRefill_i, SCT_predTake_p_i, SCT_predDest_p_i, flush_w_i, ID_deqNum_i,
        input  IQ_allowin_w_o, IQ_valid_o, IQ_pc_o, IQ_inst_o, IQ_hasException_o, IQ_ExcCode_o,
               IQ_isRefill_o, IQ_predTake_o, IQ_predDest_o
    );
    modport slave (
        input  SCT_valid_i, inst_rdata_i, SCT_originEnable_i, SCT_VAddr_i, SCT_hasException_i,
               SCT_ExcCode_i, SCT_isRefill_i, SCT_predTake_p_i, SCT_predDest_p_i, flush_w_i, ID_deqNum_i,
        output IQ_allowin_w_o, IQ_valid_o, IQ_pc_o, IQ_inst_o, IQ_hasException_o, IQ_ExcCode_o,
               IQ_isRefill_o, IQ_predTake_o, IQ_predDest_o
    );
endinterface

// File: rtl/inst_queue_compact.sv
// inst_queue_compact: packs the enabled slots of a fetch packet into ascending order, or collapses an exception packet to one entry
//   mask_i/has_exc_i/fetch_slot_i: slot enables, exception flag, VAddr[3:2]
//   slot_i: four prebuilt entries; entry_o: compacted entries; enq_num_o: number of valid outputs
module inst_queue_compact
    import inst_queue_pkg::*;
(
    input  logic [INST_NUM-1:0]       mask_i,
    input  logic                      has_exc_i,
    input  logic [1:0]                fetch_slot_i,
    input  iq_entry_t [INST_NUM-1:0]  slot_i,
    output iq_entry_t [INST_NUM-1:0]  entry_o,
    output logic [2:0]                enq_num_o
);
    logic [1:0] pos;
    logic [1:0] low;
    always_comb begin
        entry_o = '0;
        pos     = '0;
        // an empty mask on an exception packet still names the faulting slot via VAddr[3:2]
        low     = fetch_slot_i;
        for (int i = INST_NUM - 1; i >= 0; i--) low = mask_i[i] ? 2'(i) : low;
        if (has_exc_i) begin
            entry_o[0]      = slot_i[low];
            entry_o[0].inst = '0;
        end else begin
            for (int i = 0; i < INST_NUM; i++) begin
                if (mask_i[i]) begin
                    entry_o[pos] = slot_i[i];
                    pos          = pos + 2'd1;
                end
            end
        end
    end
    assign enq_num_o = has_exc_i ? 3'd1 : popcount4(mask_i);
endmodule

// File: rtl/inst_queue.sv
// inst_queue: 16-entry fetch-side instruction queue, compacting enqueue of up to 4 slots, 0-2 dequeue to decode
//   clk, rst (synchronous, active-low); bus: inst_queue_if.slave carrying fetch packet, flush, dequeue and head entries
//   IQ_PERF_CNT_EN: adds saturating IQ_stallCnt_o / IQ_emptyCnt_o performance counters
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    inst_queue_if.slave  bus
`ifdef IQ_PERF_CNT_EN
    ,
    output logic [31:0]  IQ_stallCnt_o,
    output logic [31:0]  IQ_emptyCnt_o
`endif
);
    logic [PTR_W:0]            rptr_q, rptr_d, wptr_q, wptr_d, count;
    iq_entry_t                 mem_q [DEPTH];
    iq_entry_t                 mem_d [DEPTH];
    iq_entry_t [INST_NUM-1:0]  slot, comp;
    iq_entry_t                 head0, head1;
    logic [2:0]                enq_num;
    logic [1:0]                deq;
    logic                      enq, allowin;
    logic [PTR_W-1:0]          ridx1;
    logic                      unused_vaddr;
    assign unused_vaddr = ^bus.SCT_VAddr_i[1:0];
    // pointers carry a wrap bit, so the plain difference is the occupancy 0..DEPTH
    assign count   = wptr_q - rptr_q;
    assign allowin = count <= (PTR_W+1)'(DEPTH - INST_NUM);
    assign enq     = bus.SCT_valid_i && allowin && !bus.flush_w_i;
    assign deq     = (count < (PTR_W+1)'(bus.ID_deqNum_i)) ? count[1:0] : bus.ID_deqNum_i;
    always_comb begin
        for (int i = 0; i < INST_NUM; i++) begin
            slot[i].pc        = {bus.SCT_VAddr_i[31:4], 2'(i), 2'b00};
            slot[i].inst      = bus.inst_rdata_i[SINGLE_WORD*i +: SINGLE_WORD];
            slot[i].has_exc   = bus.SCT_hasException_i;
            slot[i].exc_code  = bus.SCT_hasException_i ? bus.SCT_ExcCode_i : '0;
            slot[i].is_refill = bus.SCT_hasException_i && bus.SCT_isRefill_i;
            slot[i].pred_take = bus.SCT_predTake_p_i[i];
            slot[i].pred_dest = bus.SCT_predDest_p_i[SINGLE_WORD*i +: SINGLE_WORD];
        end
    end
    inst_queue_compact u_compact (
        .mask_i       (bus.SCT_originEnable_i),
        .has_exc_i    (bus.SCT_hasException_i),
        .fetch_slot_i (bus.SCT_VAddr_i[3:2]),
        .slot_i       (slot),
        .entry_o      (comp),
        .enq_num_o    (enq_num)
    );
    always_comb begin
        mem_d = mem_q;
        for (int k = 0; k < INST_NUM; k++) begin
            if (enq && 3'(k) < enq_num) mem_d[wptr_q[PTR_W-1:0] + PTR_W'(k)] = comp[k];
        end
    end
    // flush discards both this cycle's enqueue and dequeue
    assign rptr_d = bus.flush_w_i ? '0 : rptr_q + (PTR_W+1)'(deq);
    assign wptr_d = bus.flush_w_i ? '0 : enq ? wptr_q + (PTR_W+1)'(enq_num) : wptr_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            rptr_q <= '0;
            wptr_q <= '0;
            mem_q  <= '{default: '0};
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            mem_q  <= mem_d;
        end
    end
    assign ridx1  = rptr_q[PTR_W-1:0] + PTR_W'(1);
    assign head0  = mem_q[rptr_q[PTR_W-1:0]];
    assign head1  = mem_q[ridx1];
    assign bus.IQ_allowin_w_o    = allowin;
    assign bus.IQ_valid_o        = {count >= (PTR_W+1)'(2), count >= (PTR_W+1)'(1)} & {2{!bus.flush_w_i}};
    assign bus.IQ_pc_o           = {head1.pc, head0.pc};
    assign bus.IQ_inst_o         = {head1.inst, head0.inst};
    assign bus.IQ_hasException_o = {head1.has_exc, head0.has_exc};
    assign bus.IQ_ExcCode_o      = {head1.exc_code, head0.exc_code};
    assign bus.IQ_isRefill_o     = {head1.is_refill, head0.is_refill};
    assign bus.IQ_predTake_o     = {head1.pred_take, head0.pred_take};
    assign bus.IQ_predDest_o     = {head1.pred_dest, head0.pred_dest};
`ifdef IQ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, empty_cnt_q, empty_cnt_d;
    assign stall_cnt_d = (bus.SCT_valid_i && !allowin && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    assign empty_cnt_d = (count == '0 && !bus.flush_w_i && empty_cnt_q != '1) ? empty_cnt_q + 32'd1 : empty_cnt_q;
    always_ff @(posedge clk) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            empty_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            empty_cnt_q <= empty_cnt_d;
        end
    end
    assign IQ_stallCnt_o = stall_cnt_q;
    assign IQ_emptyCnt_o = empty_cnt_q;
`endif
endmodule

// File: tb/tb_inst_queue.sv
// tb_inst_queue: directed bench for inst_queue with a small in-order reference queue
module tb_inst_queue;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
        logic [4:0]  code;
        logic        refill;
        logic        take;
        logic [31:0] dest;
    } ent_t;
    localparam logic [3:0] TAKE = 4'b1010;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    ent_t q[$];
    inst_queue_if iq();
`ifdef IQ_PERF_CNT_EN
    logic [31:0] stall_cnt, empty_cnt;
`endif
    inst_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (iq.slave)
`ifdef IQ_PERF_CNT_EN
        ,
        .IQ_stallCnt_o (stall_cnt),
        .IQ_emptyCnt_o (empty_cnt)
`endif
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    function automatic ent_t mk(input logic [31:0] va, input int s, input logic e);
        ent_t r;
        r.pc     = {va[31:4], 2'(s), 2'b00};
        r.inst   = e ? 32'h0 : va ^ (32'hC000_0000 + 32'(s));
        r.exc    = e;
        r.code   = e ? 5'h02 : 5'h00;
        r.refill = e;
        r.take   = TAKE[s];
        r.dest   = va + 32'h1000 + 32'(4 * s);
        return r;
    endfunction
    // one clock: drive, check heads against the model, advance, update the model
    task automatic cycle(input logic v, input logic [3:0] m, input logic [31:0] va, input logic e,
                         input logic [1:0] dn, input logic fl);
        int sz;
        int d;
        int s;
        logic [127:0] words, dests;
        sz = q.size();
        for (int i = 0; i < 4; i++) begin
            words[32*i +: 32] = va ^ (32'hC000_0000 + 32'(i));
            dests[32*i +: 32] = va + 32'h1000 + 32'(4 * i);
        end
        iq.SCT_valid_i = v;
        iq.SCT_originEnable_i = m;
        iq.SCT_VAddr_i = va;
        iq.SCT_hasException_i = e;
        iq.SCT_ExcCode_i = e ? 5'h02 : 5'h00;
        iq.SCT_isRefill_i = e;
        iq.SCT_predTake_p_i = TAKE;
        iq.inst_rdata_i = words;
        iq.SCT_predDest_p_i = dests;
        iq.flush_w_i = fl;
        iq.ID_deqNum_i = dn;
        #1;
        check("valid", 64'(iq.IQ_valid_o), fl ? 64'd0 : 64'({sz >= 2, sz >= 1}));
        check("allowin", 64'(iq.IQ_allowin_w_o), 64'(sz <= 12));
        if (sz >= 1) begin
            check("pc0", 64'(iq.IQ_pc_o[31:0]), 64'(q[0].pc));
            check("inst0", 64'(iq.IQ_inst_o[31:0]), 64'(q[0].inst));
            check("meta0", 64'({iq.IQ_hasException_o[0], iq.IQ_ExcCode_o[4:0], iq.IQ_isRefill_o[0],
                                iq.IQ_predTake_o[0], iq.IQ_predDest_o[31:0]}),
                  64'({q[0].exc, q[0].code, q[0].refill, q[0].take, q[0].dest}));
        end
        if (sz >= 2) begin
            check("pc1", 64'(iq.IQ_pc_o[63:32]), 64'(q[1].pc));
            check("inst1", 64'(iq.IQ_inst_o[63:32]), 64'(q[1].inst));
            check("meta1", 64'({iq.IQ_hasException_o[1], iq.IQ_ExcCode_o[9:5], iq.IQ_isRefill_o[1],
                                iq.IQ_predTake_o[1], iq.IQ_predDest_o[63:32]}),
                  64'({q[1].exc, q[1].code, q[1].refill, q[1].take, q[1].dest}));
        end
        @(posedge clk);
        #1;
        if (fl) q.delete();
        else begin
            d = (int'(dn) < sz) ? int'(dn) : sz;
            repeat (d) void'(q.pop_front());
            if (v && sz <= 12) begin
                if (e) begin
                    s = int'(va[3:2]);
                    for (int i = 3; i >= 0; i--) if (m[i]) s = i;
                    q.push_back(mk(va, s, 1'b1));
                end else begin
                    for (int i = 0; i < 4; i++) if (m[i]) q.push_back(mk(va, i, 1'b0));
                end
            end
        end
        iq.SCT_valid_i = 1'b0;
        iq.flush_w_i = 1'b0;
        iq.ID_deqNum_i = 2'd0;
    endtask
    task automatic drain();
        for (int n = 0; n < 20 && q.size() > 0; n++) cycle(1'b0, 4'h0, 32'h0, 1'b0, 2'd2, 1'b0);
        check("drain_empty", 64'(iq.IQ_valid_o), 64'd0);
    endtask
    initial begin
        iq.SCT_valid_i = 1'b0;
        iq.inst_rdata_i = '0;
        iq.SCT_originEnable_i = '0;
        iq.SCT_VAddr_i = '0;
        iq.SCT_hasException_i = 1'b0;
        iq.SCT_ExcCode_i = '0;
        iq.SCT_isRefill_i = 1'b0;
        iq.SCT_predTake_p_i = '0;
        iq.SCT_predDest_p_i = '0;
        iq.flush_w_i = 1'b0;
        iq.ID_deqNum_i = 2'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(iq.IQ_valid_o), 64'd0);
        check("rst_allowin", 64'(iq.IQ_allowin_w_o), 64'd1);
        check("rst_pc", iq.IQ_pc_o, 64'd0);
        check("rst_inst", iq.IQ_inst_o, 64'd0);
        check("rst_dest", iq.IQ_predDest_o, 64'd0);
        rst = 1'b1;
        cycle(1'b1, 4'b1111, 32'h1FC0_0000, 1'b0, 2'd0, 1'b0);
        check("t1_valid", 64'(iq.IQ_valid_o), 64'h3);
        check("t1_pc", iq.IQ_pc_o, 64'h1FC0_0004_1FC0_0000);
        check("t1_inst", iq.IQ_inst_o, 64'hDFC0_0001_DFC0_0000);
        drain();
        cycle(1'b1, 4'b0110, 32'h1FC0_0040, 1'b0, 2'd0, 1'b0);
        check("t2_pc", iq.IQ_pc_o, 64'h1FC0_0048_1FC0_0044);
        cycle(1'b0, 4'h0, 32'h0, 1'b0, 2'd2, 1'b0);
        check("t2_empty", 64'(iq.IQ_valid_o), 64'd0);
        for (int k = 0; k < 3; k++) cycle(1'b1, 4'b1111, 32'h1FC0_0100 + 32'(16 * k), 1'b0, 2'd0, 1'b0);
        cycle(1'b1, 4'b0001, 32'h1FC0_0130, 1'b0, 2'd0, 1'b0);
        check("t3_allowin13", 64'(iq.IQ_allowin_w_o), 64'd0);
        cycle(1'b1, 4'b1111, 32'h2000_0000, 1'b0, 2'd0, 1'b0);
        cycle(1'b0, 4'h0, 32'h0, 1'b0, 2'd2, 1'b0);
        check("t3_allowin11", 64'(iq.IQ_allowin_w_o), 64'd1);
        drain();
        for (int k = 0; k < 10; k++) cycle(1'b1, 4'b1111, 32'h3000_0000 + 32'(16 * k), 1'b0, 2'd2, 1'b0);
        drain();
        cycle(1'b1, 4'b1100, 32'h1FC0_0200, 1'b1, 2'd0, 1'b0);
        check("t5_valid", 64'(iq.IQ_valid_o), 64'h1);
        check("t5_pc", 64'(iq.IQ_pc_o[31:0]), 64'h1FC0_0208);
        check("t5_inst", 64'(iq.IQ_inst_o[31:0]), 64'h0);
        check("t5_exc", 64'({iq.IQ_hasException_o[0], iq.IQ_isRefill_o[0], iq.IQ_ExcCode_o[4:0]}), 64'h62);
        drain();
        cycle(1'b1, 4'b0000, 32'h1FC0_030C, 1'b1, 2'd0, 1'b0);
        check("t5_mask0_pc", 64'(iq.IQ_pc_o[31:0]), 64'h1FC0_030C);
        drain();
        cycle(1'b1, 4'b1111, 32'h4000_0000, 1'b0, 2'd0, 1'b0);
        cycle(1'b1, 4'b0011, 32'h4000_0010, 1'b0, 2'd0, 1'b0);
        cycle(1'b1, 4'b1111, 32'h4000_0020, 1'b0, 2'd2, 1'b1);
        check("t6_valid", 64'(iq.IQ_valid_o), 64'd0);
        check("t6_allowin", 64'(iq.IQ_allowin_w_o), 64'd1);
        cycle(1'b1, 4'b0001, 32'h5000_0000, 1'b0, 2'd0, 1'b0);
        check("t6_after_valid", 64'(iq.IQ_valid_o), 64'h1);
        check("t6_after_pc", 64'(iq.IQ_pc_o[31:0]), 64'h5000_0000);
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
